fb_dma_writer: RTL and testbench
================================

# fb_dma_writer

Write-side DMA engine for the memory interface: accepts a 16-bit RGB565 pixel stream in the `clk` domain, buffers it in an internal FIFO, and writes it to external memory as a sequence of write bursts. It is the counterpart of the HDMI scan-out path, which only reads this memory. Typical sources are the capture logic and the host-upload path filling a framebuffer at `cfg_base`.

## Interface
Parameters:
- `FIFO_AW`, default 8: log2 of the FIFO depth in 16-bit words (256 words).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset: asynchronous, active-high.
- `cfg_base`  in  23  start word address. Sampled on `start`.
- `cfg_words`  in  23  total words to write. Sampled on `start`.
- `cfg_burst`  in  7  burst length minus 1 (1..128 words). Sampled on `start`.
- `start`  in  1  one-cycle pulse; begins a transfer. Ignored while `busy`.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse when the last burst completes.
- `in_data`  in  16  pixel word.
- `in_valid`  in  1  pixel word present.
- `in_ready`  out  1  word accepted when `in_valid & in_ready`.
- `mi_addr`  out  23  burst start word address.
- `mi_len`  out  7  burst length minus 1.
- `mi_rw`  out  1  tied to 0 (write).
- `mi_valid`  out  1  request valid.
- `mi_ready`  in  1  request accepted when `mi_valid & mi_ready`.
- `mi_wdata`  out  16  current write word.
- `mi_wack`  in  1  controller consumed `mi_wdata` this cycle.
- `mi_wlast`  in  1  qualifies `mi_wack`: this is the last word of the burst.

## Operation
- **Counters:**
  - `acc_rem` (23b) counts words still to accept from the stream.
  - `wr_rem` (23b) counts words still to issue in bursts.
  - `addr` (23b) holds the next burst address.
  - All three load from the `cfg_*` inputs on `start`.
- **`in_ready`:** equals `busy & ~fifo_full & (acc_rem != 0)`. Each accept pushes the word into the FIFO and decrements `acc_rem`.
- **Burst length:** `blen = min(cfg_burst+1, wr_rem)`. The comparison uses 8-bit operands and must not overflow.
- **State machine:**
  - **IDLE:** `busy=0`. On `start`:
    - if `cfg_words==0`, pulse `done` next cycle and stay in IDLE;
    - otherwise go to WAIT.
  - **WAIT:** when `fifo_level >= blen`, latch `mi_len = blen-1` and `mi_addr = addr`, then go to REQ. The check ensures a burst never starts without all of its data already buffered, so the FIFO can never underrun mid-burst.
  - **REQ:** `mi_valid=1`, with `mi_addr` and `mi_len` held stable. On `mi_ready`:
    - `addr += blen` (mod 2^23, wraps silently);
    - `wr_rem -= blen`;
    - go to DATA.
  - **DATA:**
    - `mi_wdata` shows the FIFO head; each `mi_wack` pops one word.
    - On `mi_wack & mi_wlast`: if `wr_rem==0`, go to IDLE and pulse `done`; otherwise go to WAIT.
- **FIFO:** first-word-fall-through. `fifo_level` counts stored words including any prefetch register.
- **Protocol errors:**
  - `mi_wack` outside DATA is ignored.
  - `mi_wlast` arriving before `blen` acks ends the burst anyway; the unsent words remain in the FIFO and lead the next burst.
  - Conformance tests do not cover these cases.

## Timing
- **Reset values:**
  - outputs: `busy=0`, `done=0`, `in_ready=0`, `mi_valid=0`, `mi_addr=0`, `mi_len=0`, `mi_rw=0`, `mi_wdata` don't-care;
  - internal: FIFO empty, state IDLE.
- **Reset mid-burst:** everything is cleared immediately. The controller side is reset by the same `rst`.
- **Start:**
  - `busy` rises the cycle after `start`;
  - `in_ready` may rise that same cycle.
- **Data to request latency:**
  - a word pushed in cycle N counts in `fifo_level` at N+1;
  - WAIT to REQ takes 1 cycle, so the earliest `mi_valid` is N+2 after the `blen`-th word is pushed.
- **Request hold:** `mi_valid` stays high until `mi_ready`. There is no timeout.
- **Write data:**
  - `mi_wdata` is valid from the cycle of `mi_ready` acceptance;
  - after each `mi_wack`, the next word is valid in the following cycle;
  - back-to-back `mi_wack` on consecutive cycles must be sustained.
- **Completion:**
  - `done` pulses, and `busy` falls, in the cycle after the final `mi_wack & mi_wlast`;
  - a `start` arriving in that same cycle is accepted.
- **Concurrency:** stream accept and FIFO pop may happen in the same cycle; `fifo_level` is unchanged in that case.
- **Full FIFO:** when the FIFO is full, `in_ready=0` and a push is never lost.

## Test plan
- **Single full burst:** base=0x000100, words=64, burst=63, stream continuous, `mi_ready`/`mi_wack` always 1.
  - One request: addr 0x000100, len 63.
  - 64 acks carry data 0..63 in order.
  - `done` pulses once.
- **Tail burst:** words=100, burst=31.
  - Requests: (0x0, 31), (0x20, 31), (0x40, 31), (0x60, 3).
  - `busy` stays high until the 100th ack.
- **Backpressure:**
  - setup: FIFO_AW=4, words=40, burst=15, `mi_ready` delayed 20 cycles;
  - required: `in_ready` drops with 16 words stored, no word is lost or duplicated, and `mi_valid` is held stable until `mi_ready`.
- **Gated data:**
  - setup: in_valid 1-in-4 and random `mi_wack` gaps;
  - required: no request is issued before `blen` words are buffered, and the output sequence equals the input sequence.
- **Edge starts:**
  - words=0: `done` the cycle after `start`, no request issued.
  - `start` while busy: ignored.
  - base=0x7FFFF0, words=32, burst=15: second request addr wraps to 0x000000.
- **Async reset during DATA:** assert `rst` after 5 acks.
  - All outputs take their reset values immediately.
  - A new start afterward completes correctly.

Source files
------------

// File: rtl/fb_dma_writer.sv
// fb_dma_writer: turns an RGB565 pixel stream into memory write bursts.
// A FWFT FIFO sits between the stream and the memory controller. A burst is
// requested only once every word it needs is already buffered.

// Purpose: generic first-word-fall-through FIFO built on a register array.
// Latency: a pushed word shows on head/level one cycle after the push.
// Backpressure: push is masked when full, pop is masked when empty.
module fb_fifo #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_q [2**AW];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok;
  logic          pop_ok;

  // The count can only reach 2**AW when full, so its top bit is the full flag
  assign full    = cnt_q[AW];
  assign empty   = (cnt_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];
  assign level   = cnt_q;

  // Pointer and occupancy update; push and pop together leave the count alone
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  // Storage array; contents need no reset because the count guards every read
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// Purpose: write-side DMA; buffers pixels and issues write bursts to memory.
// Latency: mi_valid is raised 2 cycles after the blen-th word of a burst is pushed.
// Backpressure: in_ready drops when the FIFO is full or all words are accepted; mi_valid holds until mi_ready.
module fb_dma_writer #(
  parameter int FIFO_AW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [22:0] cfg_base,
  input  logic [22:0] cfg_words,
  input  logic [6:0]  cfg_burst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [22:0] mi_addr,
  output logic [6:0]  mi_len,
  output logic        mi_rw,
  output logic        mi_valid,
  input  logic        mi_ready,
  output logic [15:0] mi_wdata,
  input  logic        mi_wack,
  input  logic        mi_wlast
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_REQ  = 2'd2;
  localparam logic [1:0] S_DATA = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [22:0] acc_rem_q, acc_rem_d;
  logic [22:0] wr_rem_q, wr_rem_d;
  logic [22:0] addr_q, addr_d;
  logic [6:0]  burst_q, burst_d;
  logic [22:0] mi_addr_q, mi_addr_d;
  logic [6:0]  mi_len_q, mi_len_d;
  logic        done_q, done_d;

  logic [7:0]       burst_len;
  logic [7:0]       blen;
  logic             have_burst;
  logic             fifo_push;
  logic             fifo_pop;
  logic [15:0]      fifo_head;
  logic [FIFO_AW:0] fifo_level;
  logic             fifo_full;
  logic             fifo_empty;

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign mi_valid = (state_q == S_REQ);
  assign mi_rw    = 1'b0;
  assign mi_addr  = mi_addr_q;
  assign mi_len   = mi_len_q;
  assign mi_wdata = fifo_head;

  assign in_ready  = busy & ~fifo_full & (acc_rem_q != '0);
  assign fifo_push = in_valid & in_ready;
  // Acks outside DATA are ignored; the empty guard keeps a stray ack from popping nothing
  assign fifo_pop  = (state_q == S_DATA) & mi_wack & ~fifo_empty;

  fb_fifo #(
    .AW (FIFO_AW),
    .DW (16)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (in_data),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .level    (fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Burst length is min(burst+1, wr_rem) in 8 bits; 128 still fits, and any
  // remainder with upper bits set is necessarily the larger operand
  always_comb begin
    burst_len = {1'b0, burst_q} + 8'd1;
    if ((wr_rem_q[22:8] != '0) || (wr_rem_q[7:0] >= burst_len)) begin
      blen = burst_len;
    end else begin
      blen = wr_rem_q[7:0];
    end
    have_burst = (32'(fifo_level) >= 32'(blen));
  end

  // Transfer sequencing: wait for a full burst in the FIFO, request, then stream it out
  always_comb begin
    state_d   = state_q;
    acc_rem_d = acc_rem_q;
    wr_rem_d  = wr_rem_q;
    addr_d    = addr_q;
    burst_d   = burst_q;
    mi_addr_d = mi_addr_q;
    mi_len_d  = mi_len_q;
    done_d    = 1'b0;

    if (fifo_push) begin
      acc_rem_d = acc_rem_q - 23'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_words == '0) begin
            done_d = 1'b1;
          end else begin
            acc_rem_d = cfg_words;
            wr_rem_d  = cfg_words;
            addr_d    = cfg_base;
            burst_d   = cfg_burst;
            state_d   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (have_burst) begin
          mi_addr_d = addr_q;
          mi_len_d  = 7'(blen - 8'd1);
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (mi_ready) begin
          addr_d   = addr_q + {15'd0, blen};
          wr_rem_d = wr_rem_q - {15'd0, blen};
          state_d  = S_DATA;
        end
      end
      default: begin
        // An early wlast closes the burst; unsent words lead the next one
        if (mi_wack && mi_wlast) begin
          if (wr_rem_q == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
    endcase
  end

  // Control and address registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_rem_q <= '0;
      wr_rem_q  <= '0;
      addr_q    <= '0;
      burst_q   <= '0;
      mi_addr_q <= '0;
      mi_len_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_rem_q <= acc_rem_d;
      wr_rem_q  <= wr_rem_d;
      addr_q    <= addr_d;
      burst_q   <= burst_d;
      mi_addr_q <= mi_addr_d;
      mi_len_q  <= mi_len_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_fb_dma_writer.sv
// Bench for fb_dma_writer: table of transfers run through a cycle-level
// scoreboard; a second instance with a 16-word FIFO covers backpressure.
module tb_fb_dma_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [22:0] cfg_base, cfg_words;
  logic [6:0]  cfg_burst;
  logic        start;
  logic [15:0] in_data;
  logic        in_valid;
  logic        mi_ready, mi_wack, mi_wlast;
  logic        sel;

  logic        a_busy, a_done, a_in_ready, a_mi_rw, a_mi_valid;
  logic [22:0] a_mi_addr;
  logic [6:0]  a_mi_len;
  logic [15:0] a_mi_wdata;
  logic        b_busy, b_done, b_in_ready, b_mi_rw, b_mi_valid;
  logic [22:0] b_mi_addr;
  logic [6:0]  b_mi_len;
  logic [15:0] b_mi_wdata;

  fb_dma_writer #(.FIFO_AW(8)) u_dut_a (
    .clk(clk), .rst(rst),
    .cfg_base(cfg_base), .cfg_words(cfg_words), .cfg_burst(cfg_burst),
    .start(start & ~sel), .busy(a_busy), .done(a_done),
    .in_data(in_data), .in_valid(in_valid & ~sel), .in_ready(a_in_ready),
    .mi_addr(a_mi_addr), .mi_len(a_mi_len), .mi_rw(a_mi_rw),
    .mi_valid(a_mi_valid), .mi_ready(mi_ready & ~sel), .mi_wdata(a_mi_wdata),
    .mi_wack(mi_wack & ~sel), .mi_wlast(mi_wlast & ~sel)
  );

  fb_dma_writer #(.FIFO_AW(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .cfg_base(cfg_base), .cfg_words(cfg_words), .cfg_burst(cfg_burst),
    .start(start & sel), .busy(b_busy), .done(b_done),
    .in_data(in_data), .in_valid(in_valid & sel), .in_ready(b_in_ready),
    .mi_addr(b_mi_addr), .mi_len(b_mi_len), .mi_rw(b_mi_rw),
    .mi_valid(b_mi_valid), .mi_ready(mi_ready & sel), .mi_wdata(b_mi_wdata),
    .mi_wack(mi_wack & sel), .mi_wlast(mi_wlast & sel)
  );

  logic        busy, done, in_ready, mi_rw, mi_valid;
  logic [22:0] mi_addr;
  logic [6:0]  mi_len;
  logic [15:0] mi_wdata;
  assign busy     = sel ? b_busy     : a_busy;
  assign done     = sel ? b_done     : a_done;
  assign in_ready = sel ? b_in_ready : a_in_ready;
  assign mi_rw    = sel ? b_mi_rw    : a_mi_rw;
  assign mi_valid = sel ? b_mi_valid : a_mi_valid;
  assign mi_addr  = sel ? b_mi_addr  : a_mi_addr;
  assign mi_len   = sel ? b_mi_len   : a_mi_len;
  assign mi_wdata = sel ? b_mi_wdata : a_mi_wdata;

  typedef struct {
    logic        sel;
    logic [22:0] base;
    logic [22:0] words;
    logic [6:0]  burst;
    int          vgap;
    int          rdy_dly;
    bit          wack_rand;
    int          restart_at;
    int          abort_acks;
    int          exp_nreq;
    logic [22:0] exp_last_addr;
    logic [6:0]  exp_last_len;
    bit          exp_full;
  } vec_t;

  typedef struct {
    logic [22:0] addr;
    logic [6:0]  len;
  } req_t;

  req_t        req_q[$];
  logic [15:0] exp_q[$];
  int          nchk = 0;
  int          nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [22:0] b, input logic [22:0] w,
                              input logic [6:0] bu, input int gap, input int dly, input bit wr,
                              input int rs, input int ab, input int nr, input logic [22:0] la,
                              input logic [6:0] ll, input bit fu);
    vec_t v;
    v.sel = s; v.base = b; v.words = w; v.burst = bu; v.vgap = gap; v.rdy_dly = dly;
    v.wack_rand = wr; v.restart_at = rs; v.abort_acks = ab; v.exp_nreq = nr;
    v.exp_last_addr = la; v.exp_last_len = ll; v.exp_full = fu;
    return v;
  endfunction

  // One transfer, cycle by cycle: check outputs against the model, then drive the next inputs
  task automatic run_xfer(input vec_t v, input logic [15:0] data0, output bit aborted);
    int          sent, acks, nreq, ndone, rdy_cnt, beats_left, bl, level, depth;
    bit          in_burst, last_burst, m_busy, m_done, m_busy_n, m_done_n, saw_full, finished;
    logic [22:0] rem, a, last_addr;
    logic [6:0]  last_len;
    logic [15:0] w;
    req_t        r;

    aborted = 0; finished = 0;
    sent = 0; acks = 0; nreq = 0; ndone = 0; rdy_cnt = 0; beats_left = 0;
    in_burst = 0; last_burst = 0; saw_full = 0;
    last_addr = '0; last_len = '0;
    depth = v.sel ? 16 : 256;
    req_q.delete();
    exp_q.delete();

    rem = v.words;
    a = v.base;
    while (rem != '0) begin
      bl = int'(v.burst) + 1;
      if (int'(rem) < bl) bl = int'(rem);
      r.addr = a;
      r.len = 7'(bl - 1);
      req_q.push_back(r);
      a = a + 23'(bl);
      rem = rem - 23'(bl);
    end

    cfg_base = v.base; cfg_words = v.words; cfg_burst = v.burst; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_busy = (v.words != '0);
    m_done = (v.words == '0);

    for (int cyc = 1; cyc <= 3000; cyc++) begin
      level = exp_q.size();
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("in_ready", in_ready, (m_busy && level < depth && sent < int'(v.words)) ? 1 : 0);
      if (level == depth) saw_full = 1;
      if (done) ndone++;
      if (req_q.size() == 0) begin
        chk("no_req_expected", mi_valid, 0);
      end else if (mi_valid) begin
        chk("req_addr", mi_addr, req_q[0].addr);
        chk("req_len", mi_len, req_q[0].len);
        chk("req_rw", mi_rw, 0);
        if (rdy_cnt == 0) chk("req_buffered", (level >= int'(req_q[0].len) + 1) ? 1 : 0, 1);
      end

      if (!m_busy && !m_done && cyc > 1) begin
        finished = 1;
        break;
      end
      if (v.abort_acks != 0 && acks == v.abort_acks) begin
        aborted = 1;
        break;
      end

      m_busy_n = m_busy;
      m_done_n = 0;
      start = (cyc == v.restart_at);
      if (start) begin
        cfg_base = 23'h007777; cfg_words = 23'd3; cfg_burst = 7'd0;
      end

      mi_wack = 1'b0;
      mi_wlast = 1'b0;
      if (in_burst) begin
        mi_wack = v.wack_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (mi_wack) begin
          w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
          chk("wdata", mi_wdata, w);
          acks++;
          beats_left--;
          if (beats_left == 0) begin
            mi_wlast = 1'b1;
            in_burst = 0;
            if (last_burst) begin
              m_busy_n = 0;
              m_done_n = 1;
            end
          end
        end
      end

      mi_ready = 1'b0;
      if (mi_valid && req_q.size() > 0) begin
        rdy_cnt++;
        if (rdy_cnt > v.rdy_dly) begin
          mi_ready = 1'b1;
          if (exp_q.size() > 0) chk("wdata_at_accept", mi_wdata, exp_q[0]);
          r = req_q.pop_front();
          last_addr = mi_addr;
          last_len = mi_len;
          beats_left = int'(r.len) + 1;
          nreq++;
          rdy_cnt = 0;
          in_burst = 1;
          last_burst = (req_q.size() == 0);
        end
      end

      in_valid = (sent < int'(v.words)) && (cyc % v.vgap == 0);
      in_data = data0 + 16'(sent);
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        sent++;
      end

      @(posedge clk); #1;
      m_busy = m_busy_n;
      m_done = m_done_n;
    end

    in_valid = 1'b0; mi_ready = 1'b0; mi_wack = 1'b0; mi_wlast = 1'b0; start = 1'b0;
    if (!aborted) begin
      if (!finished) begin
        nchk++;
        nerr++;
        $display("FAIL timeout: transfer busy=%0d still running, required idle", busy);
      end
      chk("nreq", nreq, v.exp_nreq);
      chk("ndone", ndone, 1);
      chk("leftover_words", exp_q.size(), 0);
      if (v.exp_nreq > 0) begin
        chk("last_addr", last_addr, v.exp_last_addr);
        chk("last_len", last_len, v.exp_last_len);
      end
      if (v.exp_full) chk("fifo_filled", saw_full, 1);
    end
  endtask

  // Asynchronous reset mid-burst: outputs must clear before the next clock edge
  task automatic reset_mid();
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mi_valid", mi_valid, 0);
    chk("rst_mi_addr", mi_addr, 0);
    chk("rst_mi_len", mi_len, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[11];
    bit   ab;

    vecs[0]  = mk(0, 23'h000100,  23'd64, 7'd63,  1,  0, 0, 0, 0, 1, 23'h000100, 7'd63, 0);
    vecs[1]  = mk(0, 23'h000000, 23'd100, 7'd31,  1,  0, 0, 0, 0, 4, 23'h000060, 7'd3,  0);
    vecs[2]  = mk(1, 23'h002000,  23'd40, 7'd15,  1, 20, 0, 0, 0, 3, 23'h002020, 7'd7,  1);
    vecs[3]  = mk(0, 23'h000500,  23'd50, 7'd7,   4,  0, 1, 0, 0, 7, 23'h000530, 7'd1,  0);
    vecs[4]  = mk(0, 23'h000010,   23'd0, 7'd3,   1,  0, 0, 0, 0, 0, 23'h000000, 7'd0,  0);
    vecs[5]  = mk(0, 23'h000040,  23'd20, 7'd9,   1,  0, 0, 5, 0, 2, 23'h00004A, 7'd9,  0);
    vecs[6]  = mk(0, 23'h7FFFF0,  23'd32, 7'd15,  1,  0, 0, 0, 0, 2, 23'h000000, 7'd15, 0);
    vecs[7]  = mk(0, 23'h000300,  23'd16, 7'd15,  1,  0, 0, 0, 5, 1, 23'h000300, 7'd15, 0);
    vecs[8]  = mk(0, 23'h000300,  23'd16, 7'd15,  1,  0, 0, 0, 0, 1, 23'h000300, 7'd15, 0);
    vecs[9]  = mk(0, 23'h001000, 23'd130, 7'd127, 1,  0, 0, 0, 0, 2, 23'h001080, 7'd1,  0);
    vecs[10] = mk(1, 23'h000700,  23'd33, 7'd15,  2,  3, 1, 0, 0, 3, 23'h000720, 7'd0,  0);

    rst = 1'b1; sel = 1'b0; start = 1'b0;
    cfg_base = '0; cfg_words = '0; cfg_burst = '0;
    in_data = '0; in_valid = 1'b0; mi_ready = 1'b0; mi_wack = 1'b0; mi_wlast = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_mi_valid", mi_valid, 0);
    chk("reset_mi_addr", mi_addr, 0);
    chk("reset_mi_len", mi_len, 0);
    chk("reset_mi_rw", mi_rw, 0);
    chk("reset_b_busy", b_busy, 0);
    chk("reset_b_in_ready", b_in_ready, 0);

    for (int i = 0; i < 11; i++) begin
      sel = vecs[i].sel;
      run_xfer(vecs[i], 16'(i * 256), ab);
      if (ab) reset_mid();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
